// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial input, clear and parallel valid/ready output bundle of the deserializer.
interface sipo_deserializer_if #(parameter int WIDTH = 4);
    logic                     clr;
    logic                     ser_in;
    logic                     ser_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_valid;
    logic                     busy;
    logic [$clog2(WIDTH):0]   bit_cnt;
    logic                     overrun;
    modport master (
        input  clr, ser_in, ser_valid, out_ready,
        output out_data, out_valid, busy, bit_cnt, overrun
    );
    modport slave (
        output clr, ser_in, ser_valid, out_ready,
        input  out_data, out_valid, busy, bit_cnt, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: assembles qualified serial bits into WIDTH-bit words held behind a valid/ready handshake.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input logic                  clk,
    input logic                  reset,
    sipo_deserializer_if.master  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    logic [WIDTH-1:0] sr, next_sr;
    logic [CW-1:0]    cnt;
    logic [0:0]       state;
    logic             last, load;
    always_comb begin
        next_sr = MSB_FIRST ? {sr[WIDTH-2:0], bus.ser_in} : {bus.ser_in, sr[WIDTH-1:1]};
        state   = (cnt == '0) ? IDLE : SHIFT;
        last    = !bus.clr && bus.ser_valid && cnt == CW'(WIDTH - 1);
        // a completed word only lands if the holding register is free or emptied on this edge
        load    = last && (!bus.out_valid || bus.out_ready);
    end
    assign bus.busy    = state == SHIFT;
    assign bus.bit_cnt = cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr            <= '0;
            cnt           <= '0;
            bus.overrun   <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            if (bus.clr) begin
                sr          <= '0;
                cnt         <= '0;
                bus.overrun <= 1'b0;
            end else if (bus.ser_valid) begin
                sr  <= next_sr;
                cnt <= last ? '0 : cnt + CW'(1);
                if (last && !load) bus.overrun <= 1'b1;
            end
            if (load) begin
                bus.out_data  <= next_sr;
                bus.out_valid <= 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed vectors against an MSB-first and an LSB-first 4-bit instance.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vecs = 0;
    int   errs = 0;
    sipo_deserializer_if #(.WIDTH(4)) m ();
    sipo_deserializer_if #(.WIDTH(4)) l ();
    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1)) dut_m (.clk(clk), .reset(reset), .bus(m));
    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(0)) dut_l (.clk(clk), .reset(reset), .bus(l));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit lsb, input logic b, input int gap);
        if (lsb) begin l.ser_valid = 1'b1; l.ser_in = b; end
        else begin m.ser_valid = 1'b1; m.ser_in = b; end
        tick();
        l.ser_valid = 1'b0;
        m.ser_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send(1'b0, w[i], 0);
    endtask

    task automatic consume();
        m.out_ready = 1'b1;
        tick();
        m.out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] w;
        logic [3:0] exp_cnt;
        {m.clr, m.ser_in, m.ser_valid, m.out_ready} = '0;
        {l.clr, l.ser_in, l.ser_valid, l.out_ready} = '0;
        #3;
        chk("rst_data", 32'(m.out_data), 0);
        chk("rst_valid", 32'(m.out_valid), 0);
        chk("rst_busy", 32'(m.busy), 0);
        chk("rst_cnt", 32'(m.bit_cnt), 0);
        chk("rst_ovr", 32'(m.overrun), 0);
        @(negedge clk) reset = 1'b1;
        // 1: back-to-back bits 1,0,1,1
        w = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            exp_cnt = 4'((i + 1) % 4);
            m.ser_valid = 1'b1;
            m.ser_in = w[3-i];
            tick();
            chk("t1_cnt", 32'(m.bit_cnt), 32'(exp_cnt));
            chk("t1_busy", 32'(m.busy), (i < 3) ? 1 : 0);
            if (i == 2) chk("t1_early_valid", 32'(m.out_valid), 0);
        end
        m.ser_valid = 1'b0;
        chk("t1_data", 32'(m.out_data), 32'hb);
        chk("t1_valid", 32'(m.out_valid), 1);
        consume();
        chk("t2_pre_valid", 32'(m.out_valid), 0);
        // 2: same stream with idle gaps
        send(1'b0, 1'b1, 0);
        send(1'b0, 1'b0, 3);
        chk("t2_gap_cnt", 32'(m.bit_cnt), 2);
        send(1'b0, 1'b1, 1);
        send(1'b0, 1'b1, 0);
        chk("t2_data", 32'(m.out_data), 32'hb);
        chk("t2_valid", 32'(m.out_valid), 1);
        consume();
        chk("t2_cons_valid", 32'(m.out_valid), 0);
        chk("t2_cons_data", 32'(m.out_data), 32'hb);
        // 3: overrun while held, then clr
        send_word(4'b1011);
        send_word(4'b0101);
        chk("t3_ovr", 32'(m.overrun), 1);
        chk("t3_data", 32'(m.out_data), 32'hb);
        chk("t3_valid", 32'(m.out_valid), 1);
        send(1'b0, 1'b1, 0);
        m.clr = 1'b1;
        m.ser_valid = 1'b1;
        m.ser_in = 1'b1;
        tick();
        m.clr = 1'b0;
        m.ser_valid = 1'b0;
        chk("t3_clr_ovr", 32'(m.overrun), 0);
        chk("t3_clr_valid", 32'(m.out_valid), 1);
        chk("t3_clr_cnt", 32'(m.bit_cnt), 0);
        chk("t3_clr_data", 32'(m.out_data), 32'hb);
        // 4: completion on the same edge as consume
        consume();
        send_word(4'b1100);
        chk("t4_held", 32'(m.out_data), 32'hc);
        send(1'b0, 1'b0, 0);
        send(1'b0, 1'b0, 0);
        send(1'b0, 1'b1, 0);
        m.out_ready = 1'b1;
        send(1'b0, 1'b1, 0);
        m.out_ready = 1'b0;
        chk("t4_data", 32'(m.out_data), 32'h3);
        chk("t4_valid", 32'(m.out_valid), 1);
        chk("t4_ovr", 32'(m.overrun), 0);
        // 5: LSB-first instance
        send(1'b1, 1'b1, 0);
        send(1'b1, 1'b0, 0);
        send(1'b1, 1'b0, 0);
        send(1'b1, 1'b0, 0);
        chk("t5_data", 32'(l.out_data), 32'h1);
        chk("t5_valid", 32'(l.out_valid), 1);
        // 6: async reset mid-word with a word held
        send(1'b0, 1'b0, 0);
        send(1'b0, 1'b1, 0);
        chk("t6_pre_cnt", 32'(m.bit_cnt), 2);
        #3 reset = 1'b0;
        #1;
        chk("t6_rst_data", 32'(m.out_data), 0);
        chk("t6_rst_valid", 32'(m.out_valid), 0);
        chk("t6_rst_busy", 32'(m.busy), 0);
        chk("t6_rst_cnt", 32'(m.bit_cnt), 0);
        chk("t6_rst_ldata", 32'(l.out_data), 0);
        @(negedge clk) reset = 1'b1;
        #1;
        send_word(4'b0110);
        chk("t6_data", 32'(m.out_data), 32'h6);
        chk("t6_valid", 32'(m.out_valid), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
